// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers used by the round stages.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    // Low byte of the AES reduction polynomial x^8 + x^4 + x^3 + x + 1.
    localparam logic [7:0] AesPoly = 8'h1B;

    // Multiply by {02} in GF(2^8).
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AesPoly : 8'h00);
    endfunction

    // Multiply by {03} in GF(2^8).
    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_single_column.sv
// Combinational MixColumns on one 32-bit column (row 0 in the MSB).
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    // Circulant {02 03 01 01} matrix applied to the column bytes.
    always_comb begin
        a0 = col_i[31:24];
        a1 = col_i[23:16];
        a2 = col_i[15:8];
        a3 = col_i[7:0];
        b0 = xtime(a0) ^ gmul3(a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ gmul3(a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ gmul3(a3);
        b3 = gmul3(a0) ^ a1 ^ a2 ^ xtime(a3);
        col_o = {b0, b1, b2, b3};
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns round stage: four parallel column mixers feeding an
// enable-gated, asynchronously cleared 128-bit output register.
module mix_columns
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic [127:0] data_in,
    output logic [127:0] data_out
);

    state_t mixed;
    state_t data_d;
    state_t data_q;

    // Column c occupies bits [127-32c -: 32].
    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_single_column u_col (
            .col_i (data_in[127-32*c -: 32]),
            .col_o (mixed[127-32*c -: 32])
        );
    end

    // Load the transformed state only on enabled edges; otherwise hold.
    always_comb begin
        data_d = enable ? mixed : data_q;
    end

    // Output register; reset clears it immediately.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns: reference model built on a generic
// GF(2^8) multiplier and the MixColumns coefficient matrix.
module tb_mix_columns;

    logic         clk;
    logic         n_rst;
    logic         enable;
    logic [127:0] data_in;
    logic [127:0] data_out;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;
    logic [127:0] exp_q;

    mix_columns dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .enable   (enable),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Generic shift-and-add multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input int unsigned b);
        logic [8:0] acc;
        logic [7:0] p;
        acc = {1'b0, a};
        p   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ acc[7:0];
            acc = acc << 1;
            if (acc[8]) acc = acc ^ 9'h11B;
        end
        return p;
    endfunction

    // out(r,c) = sum_k M[r][k] * in(k,c), M circulant from {2,3,1,1}.
    function automatic logic [127:0] mc_model(input logic [127:0] s);
        int unsigned base [4] = '{2, 3, 1, 1};
        logic [127:0] o;
        logic [7:0]   acc;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gf_mul(s[127-32*c-8*k -: 8], base[(k - r + 4) % 4]);
                o[127-32*c-8*r -: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference register: mirrors the stage's observable behaviour.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) exp_q <= '0;
        else if (enable) exp_q <= mc_model(data_in);
    end

    // Per-cycle comparison just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (chk_on) check("cycle", data_out, exp_q);
    end

    task automatic load_and_check(input string name, input logic [127:0] din,
                                  input logic [127:0] want);
        @(negedge clk);
        data_in = din;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        check(name, data_out, want);
    endtask

    initial begin
        logic [31:0]  fin [4];
        logic [31:0]  fout [4];
        logic [127:0] din, dout, held;

        fin  = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        fout = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};

        // Pin the reference model with known vectors.
        check("model_single", mc_model(128'hd4bf5d30_00000000_00000000_00000000),
              128'h046681e5_00000000_00000000_00000000);
        din = {fin[0], fin[1], fin[2], fin[3]};
        check("model_fips", mc_model(din), {fout[0], fout[1], fout[2], fout[3]});
        din = {32'hd4d4d4d5, 32'h2d26314c, 64'h0};
        check("model_xtime", mc_model(din), {32'hd5d5d7d6, 32'h4d7ebdf8, 64'h0});

        // Reset held with enable high and all-ones input.
        n_rst   = 1'b0;
        enable  = 1'b1;
        data_in = '1;
        chk_on  = 1'b1;
        #1;
        check("reset_init", data_out, 128'h0);
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold", data_out, 128'h0);

        // Release, load all-ones (MixColumns of FF.. is FF..), then clear mid-cycle.
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("load_ones", data_out, '1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_clear", data_out, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        load_and_check("single_col", 128'hd4bf5d30_00000000_00000000_00000000,
                       128'h046681e5_00000000_00000000_00000000);
        load_and_check("zero", 128'h0, 128'h0);

        // FIPS columns rotated through every slot.
        for (int r = 0; r < 4; r++) begin
            din  = {fin[r], fin[(r+1)%4], fin[(r+2)%4], fin[(r+3)%4]};
            dout = {fout[r], fout[(r+1)%4], fout[(r+2)%4], fout[(r+3)%4]};
            load_and_check("fips_rot", din, dout);
        end

        load_and_check("xtime_cols",
                       {32'hd4d4d4d5, 32'h2d26314c, 32'h2d26314c, 32'hd4d4d4d5},
                       {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'hd5d5d7d6});

        // Enable hold: output frozen while input wanders.
        held = {fout[1], fout[2], fout[3], fout[0]};
        load_and_check("hold_load", {fin[1], fin[2], fin[3], fin[0]}, held);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enable  = 1'b0;
            data_in = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            check("hold", data_out, held);
        end
        load_and_check("hold_release", 128'hd4bf5d30_00000000_00000000_00000000,
                       128'h046681e5_00000000_00000000_00000000);

        // Reset asserted exactly on an enabled edge must not load.
        @(negedge clk);
        data_in = '1;
        enable  = 1'b1;
        @(posedge clk);
        n_rst = 1'b0;
        #1;
        check("reset_on_edge", data_out, 128'h0);
        @(negedge clk);
        n_rst = 1'b1;

        // Back-to-back random states with an occasional idle cycle.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            data_in = {$urandom, $urandom, $urandom, $urandom};
            enable  = ($urandom_range(0, 9) != 0);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #2;
        chk_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
